instruction_fetch: RTL and testbench

//   Fetch stage directly upstream of the Controller. Holds the PC and requests
//   32-bit instructions from the instruction cache over a req/ready handshake.

---
 rtl/instruction_fetch_if.sv | 23 ++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-cache request/response bundle between the fetch stage and the cache.
interface instruction_fetch_if #(
    parameter int unsigned PC_WIDTH = 64
) ();
    logic                imemReq;
    logic [PC_WIDTH-1:0] imemAddr;
    logic                imemReady;
    logic [31:0]         imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one instruction at a time from the cache,
// presents it downstream and resolves the next PC from branch/zero flags.
module instruction_fetch #(
    parameter int unsigned         PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter bit                  HALT_ON_ZERO = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_fetch_if.master  imem,
    output logic [31:0]          instruction,
    output logic                 instructionValid,
    output logic [PC_WIDTH-1:0]  pcOut,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 unconditionalBranch,
    input  logic                 aluZero,
    output logic                 halted,
    output logic [31:0]          retireCount
);

    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [PC_WIDTH-1:0]     pc, pc_n;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_n;
    logic [31:0]             retire_q, retire_n;

    logic [PC_WIDTH-1:0]     offset_b;
    logic [PC_WIDTH-1:0]     offset_cb;
    logic [PC_WIDTH-1:0]     next_pc;

    // Word offsets: imm26 for B, imm19 (bits 23:5) for CB, both scaled by 4.
    assign offset_b  = {{(PC_WIDTH-28){instr_q[25]}}, instr_q[25:0], 2'b00};
    assign offset_cb = {{(PC_WIDTH-21){instr_q[23]}}, instr_q[23:5], 2'b00};

    always_comb begin
        next_pc = pc + PC_WIDTH'(4);
        if (unconditionalBranch) begin
            next_pc = pc + offset_b;
        end else if (branch && aluZero) begin
            next_pc = pc + offset_cb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instr_q  <= '0;
            retire_q <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr_q  <= instr_n;
            retire_q <= retire_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        instr_n  = instr_q;
        retire_n = retire_q;
        case (state)
            FETCH: begin
                if (imem.imemReady) begin
                    if (HALT_ON_ZERO && (imem.imemData == 32'h0)) begin
                        state_n = HALT;
                    end else begin
                        instr_n = imem.imemData;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Retire only when downstream accepts; flags are ignored while stalled.
                if (!stall) begin
                    pc_n     = next_pc;
                    retire_n = retire_q + 32'd1;
                    state_n  = FETCH;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign imem.imemReq     = (state == FETCH);
    assign imem.imemAddr    = pc;
    assign instruction      = instr_q;
    assign instructionValid = (state == ISSUE);
    assign pcOut            = pc;
    assign halted           = (state == HALT);
    assign retireCount      = retire_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, scoreboarded bench for instruction_fetch, including a second
// instance started near the top of the address space to exercise PC wrap.
module tb_instruction_fetch;

    localparam logic [31:0] ADD_W   = 32'h8B02_0020;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_if #(.PC_WIDTH(64)) m_if ();
    instruction_fetch_if #(.PC_WIDTH(64)) w_if ();

    logic        stall, branch, ub, zero;
    logic [31:0] instr, retire;
    logic        ivalid, halted;
    logic [63:0] pc_out;

    logic [31:0] w_instr, w_retire;
    logic        w_ivalid, w_halted;
    logic [63:0] w_pc_out;

    instruction_fetch #(.PC_WIDTH(64), .RESET_PC(64'h0), .HALT_ON_ZERO(1'b1)) dut (
        .clock(clk), .reset(rst), .imem(m_if.master),
        .instruction(instr), .instructionValid(ivalid), .pcOut(pc_out),
        .stall(stall), .branch(branch), .unconditionalBranch(ub), .aluZero(zero),
        .halted(halted), .retireCount(retire)
    );

    instruction_fetch #(.PC_WIDTH(64), .RESET_PC(WRAP_PC), .HALT_ON_ZERO(1'b1)) u_wrap (
        .clock(clk), .reset(rst), .imem(w_if.master),
        .instruction(w_instr), .instructionValid(w_ivalid), .pcOut(w_pc_out),
        .stall(1'b0), .branch(1'b0), .unconditionalBranch(1'b0), .aluZero(1'b0),
        .halted(w_halted), .retireCount(w_retire)
    );

    assign w_if.imemReady = 1'b1;
    assign w_if.imemData  = ADD_W;

    int          passed = 0;
    int          total  = 0;
    logic [63:0] mpc;
    logic [31:0] mretire;
    exp_t        sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model_next(input logic [63:0] p, input logic [31:0] w,
                                               input logic b, input logic u, input logic z);
        logic signed [25:0] i26;
        logic signed [18:0] i19;
        i26 = w[25:0];
        i19 = w[23:5];
        if (u)           return p + 64'(longint'(i26) * 4);
        else if (b && z) return p + 64'(longint'(i19) * 4);
        else             return p + 64'd4;
    endfunction

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; ub = 1'b0; zero = 1'b0;
        m_if.imemReady = 1'b0; m_if.imemData = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mpc = 64'h0; mretire = 32'h0;
        sb.delete();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!m_if.imemReq && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_timeout", 64'(m_if.imemReq), 64'd1);
    endtask

    // One instruction: fetch, optional stall cycles, then retire with given flags.
    task automatic run_instr(input logic [31:0] w, input logic b, input logic u,
                             input logic z, input int nstall);
        exp_t e;
        wait_req();
        check("imemAddr", m_if.imemAddr, mpc);
        m_if.imemReady = 1'b1; m_if.imemData = w;
        sb.push_back('{pc: mpc, word: w});
        @(posedge clk); #1;
        m_if.imemReady = 1'b0;
        check("instructionValid", 64'(ivalid), 64'd1);
        check("issue_req", 64'(m_if.imemReq), 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("instruction", 64'(instr), 64'(e.word));
            check("pcOut", pc_out, e.pc);
        end
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1; branch = 1'b1; ub = 1'b1; zero = 1'b1;
            m_if.imemReady = 1'b1; m_if.imemData = ~w;
            @(posedge clk); #1;
            check("stall_instr", 64'(instr), 64'(w));
            check("stall_pcOut", pc_out, mpc);
            check("stall_req", 64'(m_if.imemReq), 64'd0);
            check("stall_valid", 64'(ivalid), 64'd1);
            check("stall_retire", 64'(retire), 64'(mretire));
        end
        m_if.imemReady = 1'b0;
        stall = 1'b0; branch = b; ub = u; zero = z;
        @(posedge clk); #1;
        branch = 1'b0; ub = 1'b0; zero = 1'b0;
        mpc = model_next(mpc, w, b, u, z);
        mretire = mretire + 32'd1;
        check("retireCount", 64'(retire), 64'(mretire));
        check("retire_valid", 64'(ivalid), 64'd0);
        check("next_imemAddr", m_if.imemAddr, mpc);
    endtask

    initial begin
        do_reset();
        // Reset state, first request in cycle 0.
        check("rst_req", 64'(m_if.imemReq), 64'd1);
        check("rst_addr", m_if.imemAddr, 64'h0);
        check("rst_valid", 64'(ivalid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);

        // Wrap instance: first address near top, second wraps to 0.
        check("wrap_addr0", w_if.imemAddr, WRAP_PC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wrap_addr1", w_if.imemAddr, 64'h0);
        check("wrap_req", 64'(w_if.imemReq), 64'd1);

        // Sequential ADDs: 0,4,8,12 then B imm26=3 at 0x10.
        for (int i = 0; i < 4; i++) run_instr(ADD_W, 1'b0, 1'b0, 1'b0, 0);
        check("seq_retire4", 64'(retire), 64'd4);
        run_instr(32'h1400_0003, 1'b0, 1'b1, 1'b0, 0);
        check("b_fwd", m_if.imemAddr, 64'h1C);

        // B -1 at 0x10.
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(ADD_W, 1'b0, 1'b0, 1'b0, 0);
        run_instr(32'h17FF_FFFF, 1'b0, 1'b1, 1'b0, 0);
        check("b_back", m_if.imemAddr, 64'h0C);

        // Walk to 0x20, CBZ taken, branch back, CBZ not taken.
        for (int i = 0; i < 5; i++) run_instr(ADD_W, 1'b0, 1'b0, 1'b0, 0);
        check("at_0x20", m_if.imemAddr, 64'h20);
        run_instr(32'hB400_0040, 1'b1, 1'b0, 1'b1, 0);
        check("cbz_taken", m_if.imemAddr, 64'h28);
        run_instr(32'h17FF_FFFE, 1'b0, 1'b1, 1'b0, 0);
        run_instr(32'hB400_0040, 1'b1, 1'b0, 1'b0, 0);
        check("cbz_not_taken", m_if.imemAddr, 64'h24);

        // Unconditional wins over conditional when both flagged.
        run_instr(32'h1400_0005, 1'b1, 1'b1, 1'b1, 0);
        check("b_priority", m_if.imemAddr, 64'h38);

        // Stall for 3 cycles with garbage flags/ready that must be ignored.
        run_instr(ADD_W, 1'b0, 1'b0, 1'b0, 3);
        check("after_stall", m_if.imemAddr, 64'h3C);

        // Reset while FETCH sees imemReady: request abandoned, nothing latched.
        wait_req();
        m_if.imemReady = 1'b1; m_if.imemData = 32'h1234_5678; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_if.imemReady = 1'b0;
        mpc = 64'h0; mretire = 32'h0;
        check("midrst_addr", m_if.imemAddr, 64'h0);
        check("midrst_req", 64'(m_if.imemReq), 64'd1);
        check("midrst_instr", 64'(instr), 64'd0);
        check("midrst_retire", 64'(retire), 64'd0);
        @(posedge clk); #1;
        check("midrst_no_issue", 64'(ivalid), 64'd0);

        // Halt word.
        run_instr(ADD_W, 1'b0, 1'b0, 1'b0, 0);
        wait_req();
        m_if.imemReady = 1'b1; m_if.imemData = 32'h0;
        @(posedge clk); #1;
        m_if.imemData = ADD_W;
        for (int i = 0; i < 5; i++) begin
            check("halted", 64'(halted), 64'd1);
            check("halt_req", 64'(m_if.imemReq), 64'd0);
            check("halt_valid", 64'(ivalid), 64'd0);
            @(posedge clk); #1;
        end
        check("halt_retire", 64'(retire), 64'd1);
        do_reset();
        check("unhalt", 64'(halted), 64'd0);
        check("unhalt_req", 64'(m_if.imemReq), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
